// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - valid/ready pipeline stage, single entry by default.
// Define PIPE_SKID_STAGE_SKID_EN for a two-entry skid variant with registered in_ready.
module pipe_skid_stage #(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic              in_xfer, out_xfer;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign count     = state_q;

`ifdef PIPE_SKID_STAGE_SKID_EN
  logic [DATA_W-1:0] skid_q, skid_d;

  // Registered-only ready: breaks the out_ready -> in_ready timing path.
  assign in_ready = !reset && !flush && (state_q != FULL);
`else
  assign in_ready = !reset && !flush && (!out_valid || out_ready);
`endif

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef PIPE_SKID_STAGE_SKID_EN
    skid_d  = skid_q;
`endif
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d = BUSY;
          main_d  = in_data;
        end
      end
      BUSY: begin
        if (in_xfer && out_xfer) begin
          main_d = in_data;
        end else if (out_xfer) begin
          state_d = EMPTY;
`ifdef PIPE_SKID_STAGE_SKID_EN
        end else if (in_xfer) begin
          state_d = FULL;
          skid_d  = in_data;
`endif
        end
      end
      FULL: begin
`ifdef PIPE_SKID_STAGE_SKID_EN
        if (out_xfer) begin
          state_d = BUSY;
          main_d  = skid_q;
        end
`else
        state_d = EMPTY;
`endif
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

`ifdef PIPE_SKID_STAGE_SKID_EN
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      skid_q <= '0;
    end else begin
      skid_q <= skid_d;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - directed and scoreboarded checks for pipe_skid_stage.
module tb_pipe_skid_stage;

  localparam int          W   = 32;
  localparam logic [W-1:0] BUB = 32'hBAD0_0BAD;
`ifdef PIPE_SKID_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_data, out_data;
  logic [1:0]   count;

  int cmps = 0;
  int errs = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] hold, popped;
  logic         ir_exp, did_pop;

  pipe_skid_stage #(.DATA_W(W), .BUBBLE_VAL(BUB)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    cmps++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step();
    in_valid = 1'b1; in_data = 32'h99; out_ready = 1'b1;
    step();
    check("rst_in_ready", W'(in_ready), 0);
    check("rst_out_valid", W'(out_valid), 0);
    check("rst_count", W'(count), 0);
    check("rst_out_data", out_data, BUB);

    reset = 1'b0; in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", W'(in_ready), 1);

    // Single transfer, latency one.
    in_valid = 1'b1; in_data = 32'h11; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    #1;
    check("first_out_valid", W'(out_valid), 1);
    check("first_out_data", out_data, 32'h11);
    check("first_count", W'(count), 1);
    step();
    check("drain_out_valid", W'(out_valid), 0);
    check("drain_count", W'(count), 0);
    check("drain_hold_data", out_data, 32'h11);

    // Back-to-back stream at full throughput.
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = W'(i);
      step();
      check("stream_data", out_data, W'(i));
      check("stream_count", W'(count), 1);
    end
    in_valid = 1'b0;
    step();
    check("stream_end_count", W'(count), 0);
    check("stream_end_data", out_data, 32'h8);

`ifdef PIPE_SKID_STAGE_SKID_EN
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA;
    step();
    in_data = 32'hB;
    step();
    in_valid = 1'b0;
    #1;
    check("skid_count2", W'(count), 2);
    check("skid_in_ready", W'(in_ready), 0);
    check("skid_head", out_data, 32'hA);
    out_ready = 1'b1;
    step();
    check("skid_pop_b", out_data, 32'hB);
    check("skid_count1", W'(count), 1);
    check("skid_ready_back", W'(in_ready), 1);
    step();
    check("skid_empty", W'(count), 0);
    check("skid_hold", out_data, 32'hB);
`else
    in_valid = 1'b1; in_data = 32'hA; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("bp_in_ready", W'(in_ready), 0);
    check("bp_head", out_data, 32'hA);
    step();
    check("bp_stable", out_data, 32'hA);
    check("bp_count", W'(count), 1);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hC;
    #1;
    check("bp_release_ready", W'(in_ready), 1);
    step();
    check("bp_replace", out_data, 32'hC);
    check("bp_replace_count", W'(count), 1);
    in_valid = 1'b0;
    step();
    check("bp_empty", W'(count), 0);
`endif

    // Flush with held entries and a competing input.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h77;
    step();
    if (CAP == 2) begin
      in_data = 32'h78;
      step();
    end
    check("pre_flush_count", W'(count), W'(CAP));
    flush = 1'b1; in_data = 32'h55;
    #1;
    check("flush_in_ready", W'(in_ready), 0);
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("flush_out_valid", W'(out_valid), 0);
    check("flush_count", W'(count), 0);
    check("flush_bubble", out_data, BUB);
    step();
    check("flush_no_55_valid", W'(out_valid), 0);
    check("flush_no_55_data", out_data, BUB);

    // Random handshakes against a queue model, with flushes and one reset+flush.
    q.delete();
    hold = BUB;
    for (int c = 0; c < 10000; c++) begin
      reset     = (c == 5000);
      flush     = (c == 5000) || ($urandom_range(0, 49) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      in_data   = $urandom;
      #1;
      if (CAP == 2) ir_exp = !reset && !flush && (q.size() < 2);
      else          ir_exp = !reset && !flush && (q.size() == 0 || out_ready);
      check("rnd_in_ready", W'(in_ready), W'(ir_exp));
      if (reset || flush) begin
        q.delete();
        hold = BUB;
      end else begin
        did_pop = 1'b0;
        if (q.size() != 0 && out_ready) begin
          popped  = q.pop_front();
          did_pop = 1'b1;
        end
        if (in_valid && ir_exp) q.push_back(in_data);
        if (did_pop && q.size() == 0) hold = popped;
      end
      step();
      check("rnd_count", W'(count), W'(q.size()));
      check("rnd_out_valid", W'(out_valid), W'(q.size() != 0));
      if (q.size() != 0) check("rnd_out_data", out_data, q[0]);
      else               check("rnd_hold_data", out_data, hold);
      if (c == 5000) check("rnd_reset_in_ready_next", W'(count), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter DATA_W, default 32: width of payload carried through the stage.
REQ-002 Parameter BUBBLE_VAL, default 0 (DATA_W bits): value loaded into out_data on reset and flush.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 flush  input  1  synchronous kill of all held entries (branch/jump redirect).
REQ-006 in_valid  input  1  upstream presents a payload.
REQ-007 in_ready  output  1  stage can accept a payload this cycle.
REQ-008 in_data  input  DATA_W  upstream payload.
REQ-009 out_valid  output  1  stage presents a payload downstream.
REQ-010 out_ready  input  1  downstream accepts this cycle.
REQ-011 out_data  output  DATA_W  payload presented downstream.
REQ-012 count  output  2  number of held entries (0..2).

Function
REQ-013 Input transfer occurs iff in_valid && in_ready; output transfer iff out_valid && out_ready; all decisions use values sampled at the posedge.
REQ-014 States: EMPTY (count 0), BUSY (count 1), FULL (count 2, reachable only with SKID_EN); out_valid SHALL equal (state != EMPTY).
REQ-015 EMPTY + input transfer -> BUSY, main register <= in_data; out_valid asserts next cycle (latency 1).
REQ-016 BUSY + input + output -> BUSY, main <= in_data; BUSY + output only -> EMPTY; BUSY + input only -> FULL, skid <= in_data (SKID_EN) — unreachable without SKID_EN since in_ready is 0.
REQ-017 FULL + output transfer -> BUSY, main <= skid; FULL + no output -> FULL, both held.
REQ-018 out_data SHALL equal the main register and remain stable while out_valid && !out_ready.
REQ-019 Payloads SHALL leave in arrival order, never duplicated or dropped except by flush/reset.
REQ-020 flush (reset low): next state EMPTY, main <= BUBBLE_VAL, skid discarded, count 0; in_ready SHALL be 0 during a flush cycle so no input transfer occurs; any output handshake in the flush cycle is not a transfer the stage accounts for.
REQ-021 After draining (output-only transfer to EMPTY), out_data holds the last transferred payload.
REQ-022 count SHALL track state exactly every cycle.

Reset
REQ-023 reset has priority over flush and all handshakes.
REQ-024 On reset: state EMPTY, out_valid 0, out_data BUBBLE_VAL, count 0, skid register 0; in_ready 0 during the reset cycle, asserted the first cycle after reset deasserts.

Configuration
REQ-025 Macro PIPE_SKID_STAGE_SKID_EN selects the skid buffer.
REQ-026 With PIPE_SKID_STAGE_SKID_EN: two entries (main + skid); in_ready = !reset && !flush && (state != FULL) from registered state only, no combinational out_ready->in_ready path; full throughput under out_ready toggling.
REQ-027 Without it: single entry, no skid register; in_ready = !reset && !flush && (!out_valid || out_ready) (combinational from out_ready); count never exceeds 1; FULL unreachable.

Verification
REQ-028 Reset then in_valid=1, in_data=0x11, out_ready=1 -> out_valid=1, out_data=0x11 next cycle, count=1.
REQ-029 Stream 0x01..0x08 continuously with out_ready=1 -> out_data 0x01..0x08 on consecutive cycles, one per clock, count stays 1.
REQ-030 SKID_EN: hold out_ready=0, push 0xA, 0xB -> count=2, in_ready=0, out_data=0xA; release out_ready -> 0xA then 0xB on consecutive cycles, in_ready=1 the cycle after the first pop.
REQ-031 Non-SKID: out_ready=0 with 0xA held -> in_ready=0 same cycle; out_ready=1 with in_valid=1, in_data=0xC -> 0xC replaces 0xA next cycle, count=1.
REQ-032 Count 2 (or 1) held, assert flush with in_valid=1, in_data=0x55 -> next cycle out_valid=0, count=0, out_data=BUBBLE_VAL, 0x55 never appears.
REQ-033 Assert reset and flush together mid-stream with random handshakes -> reset values of REQ-024; scoreboard confirms order and no loss across 10k random cycles.
